// File: rtl/dtc_link_pkg.sv
// dtc_link_pkg: link-word type codes, header/trailer field layout and FSM states
// shared by the DTC stub transmitter and its FIFO.
package dtc_link_pkg;

    localparam int DEF_STUB_W = 36;
    localparam int LINK_W     = DEF_STUB_W + 2;

    typedef logic [LINK_W-1:0] link_word_t;

    typedef enum logic [1:0] {
        WT_HEADER  = 2'b01,
        WT_STUB    = 2'b10,
        WT_TRAILER = 2'b11
    } word_type_t;

    // Header and trailer payload field positions.
    localparam int BX_LSB    = 0;
    localparam int BX_W      = 8;
    localparam int CNT_LSB   = 8;
    localparam int CNT_W     = 8;
    localparam int TRUNC_BIT = 16;
    localparam int CKSUM_LSB = 17;
    localparam int CKSUM_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_TRAILER
    } tx_state_t;

    // Folds one 36-bit stub into its 16-bit checksum contribution.
    function automatic logic [15:0] stub_fold(input logic [35:0] s);
        return s[15:0] ^ s[31:16] ^ {12'b0, s[35:32]};
    endfunction

endpackage

// File: rtl/dtc_tx_fifo.sv
// dtc_tx_fifo: synchronous first-word-fall-through FIFO; rd_data always shows the
// head entry while empty is low.
module dtc_tx_fifo #(
    parameter int W     = 45,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dtc_link_tx.sv
// dtc_link_tx: frames buffered stubs into header / stub / trailer words for the InputDTC link.
// Trailer checksum is built only when DTC_TX_CHECKSUM_EN is defined.
module dtc_link_tx
    import dtc_link_pkg::*;
#(
    parameter int STUB_W     = 36,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_STUBS  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STUB_W-1:0] stub_data,
    input  logic [7:0]        stub_bx,
    input  logic              stub_last,
    input  logic              stub_valid,
    output logic              stub_ready,
    output logic [STUB_W+1:0] link_data,
    output logic              link_valid,
    input  logic              link_ready
);
    localparam int         ENT_W    = STUB_W + 9;
    localparam logic [7:0] CNT_LAST = 8'(MAX_STUBS - 1);

    tx_state_t         state, next_state;
    logic [ENT_W-1:0]  head;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic              head_last;
    logic [7:0]        head_bx;
    logic [STUB_W-1:0] head_stub;
    logic [7:0]        ev_bx;
    logic [7:0]        stub_cnt;
    logic              trunc;
    logic              valid_c;
    logic [STUB_W+1:0] data_c;

    assign stub_ready = rst_n && !fifo_full;
    assign push       = stub_valid && stub_ready;

    dtc_tx_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data ({stub_last, stub_bx, stub_data}),
        .wr_en   (push),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign head_last = head[STUB_W+8];
    assign head_bx   = head[STUB_W+7:STUB_W];
    assign head_stub = head[STUB_W-1:0];

`ifdef DTC_TX_CHECKSUM_EN
    logic [15:0] cksum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cksum <= '0;
        end else if (state == ST_PAYLOAD && pop) begin
            cksum <= cksum ^ stub_fold(36'(head_stub));
        end else if (state == ST_TRAILER && link_ready) begin
            cksum <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ev_bx    <= '0;
            stub_cnt <= '0;
            trunc    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_HEADER) ev_bx <= head_bx;
            if (state == ST_PAYLOAD && pop) stub_cnt <= stub_cnt + 8'd1;
            if (state == ST_PAYLOAD && next_state == ST_DRAIN) trunc <= 1'b1;
            if (state == ST_TRAILER && link_ready) begin
                stub_cnt <= '0;
                trunc    <= 1'b0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        valid_c    = 1'b0;
        data_c     = '0;
        unique case (state)
            ST_IDLE: begin
                // Looking at the incoming push gives a header the cycle after the first stub.
                if (!fifo_empty || push) next_state = ST_HEADER;
            end
            ST_HEADER: begin
                valid_c                           = 1'b1;
                data_c[STUB_W+1:STUB_W]           = WT_HEADER;
                data_c[BX_LSB +: BX_W]            = head_bx;
                if (link_ready) next_state = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (!fifo_empty) begin
                    valid_c                 = 1'b1;
                    data_c[STUB_W+1:STUB_W] = WT_STUB;
                    data_c[STUB_W-1:0]      = head_stub;
                    if (link_ready) begin
                        pop = 1'b1;
                        if (head_last)                  next_state = ST_TRAILER;
                        else if (stub_cnt == CNT_LAST)  next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Discard the event's excess stubs silently up to its last one.
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_last) next_state = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                valid_c                      = 1'b1;
                data_c[STUB_W+1:STUB_W]      = WT_TRAILER;
                data_c[BX_LSB +: BX_W]       = ev_bx;
                data_c[CNT_LSB +: CNT_W]     = stub_cnt;
                data_c[TRUNC_BIT]            = trunc;
`ifdef DTC_TX_CHECKSUM_EN
                data_c[CKSUM_LSB +: CKSUM_W] = cksum;
`endif
                if (link_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign link_valid = rst_n && valid_c;
    assign link_data  = rst_n ? data_c : '0;

endmodule

// File: tb/tb_dtc_link_tx.sv
// tb_dtc_link_tx: directed bench with an event-level reference model and a per-cycle
// link monitor; honours DTC_TX_CHECKSUM_EN when the DUT is built with it.
module tb_dtc_link_tx;
    import dtc_link_pkg::*;

    localparam int MAXS = 48;
`ifdef DTC_TX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [35:0] stub_data;
    logic [7:0] stub_bx;
    logic       stub_last;
    logic       stub_valid;
    logic       stub_ready;
    link_word_t link_data;
    logic       link_valid;
    logic       link_ready;

    always #5 clk = ~clk;

    dtc_link_tx #(
        .STUB_W     (36),
        .FIFO_DEPTH (64),
        .MAX_STUBS  (MAXS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stub_data  (stub_data),
        .stub_bx    (stub_bx),
        .stub_last  (stub_last),
        .stub_valid (stub_valid),
        .stub_ready (stub_ready),
        .link_data  (link_data),
        .link_valid (link_valid),
        .link_ready (link_ready)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    link_word_t exp_q[$];
    link_word_t acc_q[$];
    int         acc_cyc[$];
    int         in_cyc[$];

    bit          in_event = 1'b0;
    int          ev_n     = 0;
    logic [7:0]  ev_bx    = '0;
    logic [15:0] ev_ck    = '0;
    bit          prev_hold = 1'b0;
    link_word_t  prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input logic [35:0] d);
        return d[15:0] ^ d[31:16] ^ {12'b0, d[35:32]};
    endfunction

    // Event-level model: header on first stub, at most MAXS stub words, trailer on last.
    task automatic model_accept(input logic [35:0] d, input logic [7:0] bx, input logic last);
        int sent;
        if (!in_event) begin
            exp_q.push_back({2'b01, 28'h0, bx});
            in_event = 1'b1;
            ev_n     = 0;
            ev_ck    = '0;
            ev_bx    = bx;
        end
        if (ev_n < MAXS) begin
            exp_q.push_back({2'b10, d});
            ev_ck = ev_ck ^ fold(d);
        end
        ev_n++;
        if (last) begin
            sent = (ev_n > MAXS) ? MAXS : ev_n;
            exp_q.push_back({2'b11, 3'b000, (CK_EN ? ev_ck : 16'h0), (ev_n > MAXS), 8'(sent), ev_bx});
            in_event = 1'b0;
        end
    endtask

    // Monitor: samples both handshakes mid-cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_link_valid", 64'(link_valid), 64'd0);
                check("rst_link_data",  64'(link_data),  64'd0);
                check("rst_stub_ready", 64'(stub_ready), 64'd0);
                exp_q.delete();
                in_event  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (stub_valid && stub_ready) begin
                    in_cyc.push_back(cyc);
                    model_accept(stub_data, stub_bx, stub_last);
                end
                if (prev_hold) begin
                    check("hold_valid", 64'(link_valid), 64'd1);
                    check("hold_data",  64'(link_data),  64'(prev_data));
                end
                if (link_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(link_valid), 64'd0);
                    end else begin
                        check("link_word", 64'(link_data), 64'(exp_q[0]));
                        if (link_ready) begin
                            acc_q.push_back(link_data);
                            acc_cyc.push_back(cyc);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                prev_hold = link_valid && !link_ready;
                prev_data = link_data;
            end
        end
    end

    task automatic push_stub(input logic [35:0] d, input logic [7:0] bx, input logic last);
        bit ok;
        int g;
        ok = 1'b0;
        g  = 0;
        stub_data  = d;
        stub_bx    = bx;
        stub_last  = last;
        stub_valid = 1'b1;
        while (!ok && g < 200) begin
            @(negedge clk);
            ok = stub_ready;
            @(posedge clk);
            #1;
            g++;
        end
        check("push_bound", 64'(ok), 64'd1);
        stub_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || in_event) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("idle_bound", 64'(g >= 3000), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int count_type(input int from, input logic [1:0] t);
        int n;
        link_word_t w;
        n = 0;
        for (int i = from; i < acc_q.size(); i++) begin
            w = acc_q[i];
            if (w[37:36] == t) n++;
        end
        return n;
    endfunction

    function automatic int find_type(input int from, input logic [1:0] t);
        link_word_t w;
        for (int i = from; i < acc_q.size(); i++) begin
            w = acc_q[i];
            if (w[37:36] == t) return i;
        end
        return -1;
    endfunction

    initial begin
        int         base;
        int         ib;
        int         idx;
        int         sz;
        int         g;
        link_word_t w;

        rst_n      = 1'b0;
        stub_valid = 1'b0;
        stub_data  = '0;
        stub_bx    = '0;
        stub_last  = 1'b0;
        link_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(stub_ready), 64'd1);
        check("idle_after_reset",  64'(link_valid), 64'd0);
        @(posedge clk);
        #1;

        // Three stubs, bx 0x12, link always ready.
        base = acc_q.size();
        ib   = in_cyc.size();
        push_stub(36'h0_0000_00A1, 8'h12, 1'b0);
        push_stub(36'h0_0000_00A2, 8'h12, 1'b0);
        push_stub(36'h0_0000_00A3, 8'h12, 1'b1);
        wait_idle();
        check("t1_word_count", 64'(acc_q.size() - base), 64'd5);
        check("t1_header",  64'(acc_q[base]),   64'({2'b01, 28'h0, 8'h12}));
        check("t1_stub0",   64'(acc_q[base+1]), 64'({2'b10, 36'h0_0000_00A1}));
        check("t1_stub2",   64'(acc_q[base+3]), 64'({2'b10, 36'h0_0000_00A3}));
        check("t1_trailer", 64'(acc_q[base+4]),
              64'({2'b11, 3'b000, (CK_EN ? 16'h00A0 : 16'h0000), 1'b0, 8'd3, 8'h12}));
        check("t1_latency",    64'(acc_cyc[base] - in_cyc[ib]),       64'd1);
        check("t1_contiguous", 64'(acc_cyc[base+4] - acc_cyc[base]), 64'd4);

        // Five stubs, link_ready toggling every cycle.
        base = acc_q.size();
        fork
            begin
                for (int i = 0; i < 5; i++) push_stub(36'h0_0003_4000 + 36'(i), 8'h34, i == 4);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    link_ready = ~link_ready;
                end
            end
        join
        link_ready = 1'b1;
        wait_idle();
        check("t2_word_count", 64'(acc_q.size() - base), 64'd7);
        check("t2_stub0", 64'(acc_q[base+1]), 64'({2'b10, 36'h0_0003_4000}));
        check("t2_stub4", 64'(acc_q[base+5]), 64'({2'b10, 36'h0_0003_4004}));
        check("t2_paced", 64'((acc_cyc[base+6] - acc_cyc[base]) >= 12), 64'd1);

        // 50 stubs against MAX_STUBS=48, then a short event.
        base = acc_q.size();
        for (int i = 0; i < 50; i++) push_stub({8'h56, 28'(i)}, 8'h56, i == 49);
        push_stub(36'h0_0000_0057, 8'h57, 1'b0);
        push_stub(36'h0_0000_0058, 8'h57, 1'b1);
        wait_idle();
        idx = find_type(base, 2'b11);
        check("t3_trailer_pos", 64'(idx - base), 64'd49);
        w = acc_q[idx];
        check("t3_trunc_fields", 64'(w[16:0]), 64'(17'h1_3056));
        check("t3_next_header", 64'(acc_q[idx+1]), 64'({2'b01, 28'h0, 8'h57}));
        w = acc_q[idx+4];
        check("t3_next_fields", 64'(w[16:0]), 64'(17'h0_0257));
        check("t3_word_count", 64'(acc_q.size() - base), 64'd54);

        // Fill the FIFO with the link stalled, then free exactly one entry.
        link_ready = 1'b0;
        base = acc_q.size();
        for (int i = 0; i < 64; i++) push_stub({8'h78, 28'(i)}, 8'h78, i == 63);
        @(negedge clk);
        check("t4_full_ready", 64'(stub_ready), 64'd0);
        @(posedge clk);
        #1;
        link_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_before_pop", 64'(stub_ready), 64'd0);
        @(posedge clk);
        #1;
        link_ready = 1'b0;
        @(negedge clk);
        check("t4_after_pop", 64'(stub_ready), 64'd1);
        @(posedge clk);
        #1;
        link_ready = 1'b1;
        wait_idle();
        check("t4_stub_words", 64'(count_type(base, 2'b10)), 64'd48);
        w = acc_q[acc_q.size()-1];
        check("t4_trunc_fields", 64'(w[16:0]), 64'(17'h1_3078));

        // Reset after two stub words of a frame.
        link_ready = 1'b0;
        base = acc_q.size();
        for (int i = 0; i < 4; i++) push_stub(36'h0_0000_9A00 + 36'(i), 8'h9A, 1'b0);
        link_ready = 1'b1;
        g = 0;
        while (count_type(base, 2'b10) < 2 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("t5_wait_bound", 64'(g >= 100), 64'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after_reset", 64'(stub_ready), 64'd1);
        sz = acc_q.size();
        repeat (5) @(posedge clk);
        #1;
        check("t5_quiet",      64'(acc_q.size()), 64'(sz));
        check("t5_valid_low",  64'(link_valid),   64'd0);
        check("t5_no_trailer", 64'(count_type(base, 2'b11)), 64'd0);
        base = acc_q.size();
        push_stub(36'h0, 8'hBC, 1'b1);
        wait_idle();
        check("t5_word_count", 64'(acc_q.size() - base), 64'd3);
        check("t5_header",  64'(acc_q[base]),   64'({2'b01, 28'h0, 8'hBC}));
        check("t5_trailer", 64'(acc_q[base+2]), 64'({2'b11, 3'b000, 16'h0, 1'b0, 8'd1, 8'hBC}));

        // Checksum field: these two stubs fold to the same value and cancel.
        base = acc_q.size();
        push_stub(36'h0_0000_0001, 8'hDE, 1'b0);
        push_stub(36'h0_0001_0000, 8'hDE, 1'b1);
        wait_idle();
        check("t6_trailer", 64'(acc_q[base+3]), 64'({2'b11, 3'b000, 16'h0, 1'b0, 8'd2, 8'hDE}));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
